counter_sweep_ctrl: RTL

Sequencer that owns an up/down step counter and drives it through programmed sweeps: count up to a bound, count down to a bound, or bounce between two bounds for N passes.
Issues the 2-bit up/down step command used by the team's counters (01 = increment, 10 = decrement, 00/11 = hold) and exposes the live count.
Sits between a host/test controller and any logic consuming a stepped count value.

---
 rtl/counter_ctrl_pkg.sv | 22 ++
 rtl/step_counter.sv | 30 +++
 rtl/counter_sweep_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the up/down step counters and the sweep sequencer:
// step command encodings, sweep mode encodings and the sweep FSM states.
package counter_ctrl_pkg;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_DEC  = 2'b10;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/step_counter.sv
// WIDTH-bit up/down counter driven by the 2-bit step command; a synchronous
// load takes priority over stepping. Counting wraps modulo 2^WIDTH.
module step_counter
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       up_dwn,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else begin
            case (up_dwn)
                CMD_INC: count <= count + WIDTH'(1);
                CMD_DEC: count <= count - WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer owning a step_counter: UP, DOWN or BOUNCE sweeps with a step
// divider. Optional pass_left output when SWEEP_PASS_CNT_EN is defined.
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [3:0]       passes,
    input  logic             abort,
    output logic [1:0]       up_dwn,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
`ifdef SWEEP_PASS_CNT_EN
    ,
    output logic [3:0]       pass_left
`endif
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    sweep_state_t     state, state_nxt;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] lo_r, hi_r;
    logic [3:0]       passes_r;
    logic [3:0]       pass_rem;
    logic [DW-1:0]    div_cnt;
    logic             tick;
    logic             load;
    logic             pass_dec;

    assign tick = (div_cnt == DIV_LAST);
    assign busy = (state != ST_IDLE);

    // start is a request taken only in IDLE; done is a single-cycle pulse in DONE.
    always_comb begin
        state_nxt = state;
        up_dwn    = CMD_HOLD;
        load      = 1'b0;
        pass_dec  = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    unique case (mode)
                        MODE_UP:     state_nxt = ST_UP;
                        MODE_DOWN:   state_nxt = ST_DOWN;
                        MODE_BOUNCE: state_nxt = ST_LOAD;
                        default:     state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else begin
                    load      = 1'b1;
                    state_nxt = (lo_r >= hi_r) ? ST_DONE : ST_UP;
                end
            end
            ST_UP: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (count == hi_r) begin
                    state_nxt = (mode_r == MODE_BOUNCE) ? ST_DOWN : ST_DONE;
                end else if (tick) begin
                    up_dwn = CMD_INC;
                end
            end
            ST_DOWN: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (count == lo_r) begin
                    if (mode_r == MODE_BOUNCE) begin
                        pass_dec  = 1'b1;
                        state_nxt = (pass_rem > 4'd1) ? ST_UP : ST_DONE;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else if (tick) begin
                    up_dwn = CMD_DEC;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_r   <= MODE_NONE;
            lo_r     <= '0;
            hi_r     <= '0;
            passes_r <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                mode_r   <= mode;
                lo_r     <= lo;
                hi_r     <= hi;
                passes_r <= passes;
            end
        end
    end

    // Divider restarts on every state change so the first step lands DIV cycles in.
    always_ff @(posedge clk) begin
        if (reset || state_nxt != state) begin
            div_cnt <= '0;
        end else if (state == ST_UP || state == ST_DOWN) begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state_nxt == ST_DONE) begin
            pass_rem <= '0;
        end else if (state == ST_LOAD) begin
            pass_rem <= (passes_r == 4'd0) ? 4'd1 : passes_r;
        end else if (pass_dec) begin
            pass_rem <= pass_rem - 4'd1;
        end
    end

`ifdef SWEEP_PASS_CNT_EN
    assign pass_left = pass_rem;
`endif

    step_counter #(
        .WIDTH(WIDTH)
    ) u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (lo_r),
        .up_dwn   (up_dwn),
        .count    (count)
    );

endmodule
